validador_pecas: RTL and testbench

VALIDADOR_PECAS -- requirements
Module: validador_pecas

---
 rtl/validador_pecas_pkg.sv | 54 +++++
 rtl/validador_pecas_gerador_celulas.sv | 55 +++++
 rtl/validador_pecas.sv | 213 +++++++++++++++++++++
 tb/tb_validador_pecas.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/validador_pecas_pkg.sv
// validador_pecas_pkg
// Shared definitions for the piece validator: piece type codes, the
// piece length table, the controller state encoding and the default
// board side length.

package validador_pecas_pkg;

    localparam int N_LADO_PADRAO = 10;

    typedef enum logic [2:0] {
        SUBMARINO    = 3'd0,
        CRUZADOR     = 3'd1,
        HIDROAVIAO   = 3'd2,
        ENCOURACADO  = 3'd3,
        PORTA_AVIOES = 3'd4
    } tipo_t;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        VERIFICA  = 2'd1,
        RESULTADO = 2'd2,
        GRAVA     = 2'd3
    } estado_t;

    // Piece fields captured when a check starts. Only bit 0 of the
    // orientation is meaningful, so only that bit is kept.
    typedef struct packed {
        logic [2:0] tipo;
        logic       jogador;
        logic [3:0] x1;
        logic [3:0] y1;
        logic       direcao;
        logic       espelha;
    } peca_t;

    function automatic logic tipo_valido(input logic [2:0] t);
        return (t <= 3'd4);
    endfunction

    // Number of cells occupied by a piece; zero for unknown codes.
    function automatic logic [2:0] comprimento(input logic [2:0] t);
        logic [2:0] len;
        case (t)
            SUBMARINO:    len = 3'd1;
            CRUZADOR:     len = 3'd2;
            HIDROAVIAO:   len = 3'd3;
            ENCOURACADO:  len = 3'd4;
            PORTA_AVIOES: len = 3'd5;
            default:      len = 3'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/validador_pecas_gerador_celulas.sv
// gerador_celulas
// Combinational cell generator: given the captured piece and the index k
// of one of its cells, produces that cell's coordinates and whether it
// falls outside the board.
// Ports:
//   tipo, x1, y1, direcao, espelha : captured piece description
//   k                              : cell index along the piece
//   x, y                           : cell coordinates (low 4 bits)
//   fora_limite                    : 1 when the cell is off the board

module gerador_celulas
    import validador_pecas_pkg::*;
#(
    parameter int N_LADO = N_LADO_PADRAO
) (
    input  logic [2:0] tipo,
    input  logic [3:0] x1,
    input  logic [3:0] y1,
    input  logic       direcao,
    input  logic       espelha,
    input  logic [2:0] k,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic       fora_limite
);

    localparam logic signed [5:0] LADO = 6'(N_LADO);

    logic signed [5:0] ao;
    logic signed [5:0] ac;
    logic signed [5:0] cx;
    logic signed [5:0] cy;

    // Arithmetic is done in 6-bit signed so that a step below zero
    // (hidroaviao mirrored at the board edge) is seen as negative
    // instead of wrapping around to a large coordinate.
    always_comb begin
        ao = signed'({3'b000, k});
        ac = 6'sd0;
        if (tipo == HIDROAVIAO && k == 3'd1) begin
            ac = espelha ? -6'sd1 : 6'sd1;
        end
        if (!direcao) begin
            cx = signed'({2'b00, x1}) + ao;
            cy = signed'({2'b00, y1}) + ac;
        end else begin
            cx = signed'({2'b00, x1}) + ac;
            cy = signed'({2'b00, y1}) + ao;
        end
        fora_limite = (cx < 6'sd0) || (cx >= LADO) || (cy < 6'sd0) || (cy >= LADO);
        x = cx[3:0];
        y = cy[3:0];
    end

endmodule

// File: rtl/validador_pecas.sv
// validador_pecas
// Validates and commits piece placements on two occupancy boards (one per
// player). A rising edge on valida starts a check of the requested piece
// one cell per cycle; a clean check is followed by writing the cells one
// per cycle and bumping that player's piece count.
// Ports:
//   clk, reset (sync, active low)
//   valida, tipo, jogador, X1, Y1, direcao, orientacao : placement request
//   conflito, pronto, ocupado                          : result / status
//   rd_jogador, rd_x, rd_y -> rd_celula                : registered board read
//   qtd_j0, qtd_j1                                     : committed piece counts

module validador_pecas
    import validador_pecas_pkg::*;
#(
    parameter int N_LADO = N_LADO_PADRAO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valida,
    input  logic [2:0] tipo,
    input  logic       jogador,
    input  logic [3:0] X1,
    input  logic [3:0] Y1,
    input  logic       direcao,
    input  logic [2:0] orientacao,
    output logic       conflito,
    output logic       pronto,
    output logic       ocupado,
    input  logic       rd_jogador,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       rd_celula,
    output logic [3:0] qtd_j0,
    output logic [3:0] qtd_j1
);

    localparam logic [4:0] LADO_RD = 5'(N_LADO);

    estado_t            estado;
    estado_t            proximo;
    peca_t              peca;
    logic [2:0]         k;
    logic               flag;
    logic               flag_nxt;
    logic               valida_q;
    logic               inicio;
    logic               ultimo;
    logic [3:0]         cel_x;
    logic [3:0]         cel_y;
    logic               fora;
    logic               ocupada;
    logic [N_LADO-1:0]  tab [2][N_LADO];
    logic               unused_orientacao;

    assign unused_orientacao = ^orientacao[2:1];

    gerador_celulas #(
        .N_LADO (N_LADO)
    ) u_gerador (
        .tipo        (peca.tipo),
        .x1          (peca.x1),
        .y1          (peca.y1),
        .direcao     (peca.direcao),
        .espelha     (peca.espelha),
        .k           (k),
        .x           (cel_x),
        .y           (cel_y),
        .fora_limite (fora)
    );

    // A check starts only on a fresh 0->1 edge of valida seen while idle;
    // edges that happen while busy are simply lost.
    assign inicio  = valida && !valida_q && (estado == OCIOSO);
    assign ultimo  = (k == comprimento(peca.tipo) - 3'd1);

    // Occupancy of the current cell; never index the board with an
    // off-board coordinate.
    always_comb begin
        ocupada = 1'b0;
        if (!fora) begin
            ocupada = tab[peca.jogador][cel_y][cel_x];
        end
    end

    assign flag_nxt = flag | fora | ocupada;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        proximo = estado;
        pronto  = 1'b0;
        ocupado = 1'b1;
        case (estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (inicio) begin
                    proximo = tipo_valido(tipo) ? VERIFICA : RESULTADO;
                end
            end
            VERIFICA: begin
                if (ultimo) begin
                    proximo = RESULTADO;
                end
            end
            RESULTADO: begin
                pronto  = 1'b1;
                proximo = flag ? OCIOSO : GRAVA;
            end
            GRAVA: begin
                if (ultimo) begin
                    proximo = OCIOSO;
                end
            end
            default: begin
                proximo = OCIOSO;
            end
        endcase
    end

    // Request capture, cell counter, conflict flag and piece counters.
    // conflito is loaded on the edge that enters RESULTADO so that it is
    // already valid while pronto is high. valida_q resets high so that a
    // valida held high across reset release is not taken as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valida_q <= 1'b1;
            peca     <= '0;
            k        <= 3'd0;
            flag     <= 1'b0;
            conflito <= 1'b0;
            qtd_j0   <= 4'd0;
            qtd_j1   <= 4'd0;
        end else begin
            valida_q <= valida;
            case (estado)
                OCIOSO: begin
                    if (inicio) begin
                        peca.tipo    <= tipo;
                        peca.jogador <= jogador;
                        peca.x1      <= X1;
                        peca.y1      <= Y1;
                        peca.direcao <= direcao;
                        peca.espelha <= orientacao[0];
                        k            <= 3'd0;
                        flag         <= !tipo_valido(tipo);
                        if (!tipo_valido(tipo)) begin
                            conflito <= 1'b1;
                        end
                    end
                end
                VERIFICA: begin
                    flag <= flag_nxt;
                    k    <= k + 3'd1;
                    if (ultimo) begin
                        conflito <= flag_nxt;
                        k        <= 3'd0;
                    end
                end
                RESULTADO: begin
                    k <= 3'd0;
                end
                GRAVA: begin
                    k <= k + 3'd1;
                    if (ultimo) begin
                        if (peca.jogador) begin
                            if (qtd_j1 != 4'hF) begin
                                qtd_j1 <= qtd_j1 + 4'd1;
                            end
                        end else begin
                            if (qtd_j0 != 4'hF) begin
                                qtd_j0 <= qtd_j0 + 4'd1;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Boards and the registered read port. Cells written during GRAVA
    // were all checked in range, so the write index is always valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < 2; j++) begin
                for (int r = 0; r < N_LADO; r++) begin
                    tab[j][r] <= '0;
                end
            end
            rd_celula <= 1'b0;
        end else begin
            if (estado == GRAVA) begin
                tab[peca.jogador][cel_y][cel_x] <= 1'b1;
            end
            if (({1'b0, rd_x} < LADO_RD) && ({1'b0, rd_y} < LADO_RD)) begin
                rd_celula <= tab[rd_jogador][rd_y][rd_x];
            end else begin
                rd_celula <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_validador_pecas.sv
// tb_validador_pecas
// Scoreboard bench for validador_pecas: each request pushes its expected
// conflict result and pronto cycle into a queue, a monitor pops and
// compares whenever pronto is seen. A reference board model computed from
// the placement rules predicts results, board contents and counts.

module tb_validador_pecas;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valida = 1'b0;
    logic [2:0] tipo = 3'd0;
    logic       jogador = 1'b0;
    logic [3:0] X1 = 4'd0;
    logic [3:0] Y1 = 4'd0;
    logic       direcao = 1'b0;
    logic [2:0] orientacao = 3'd0;
    logic       conflito;
    logic       pronto;
    logic       ocupado;
    logic       rd_jogador = 1'b0;
    logic [3:0] rd_x = 4'd0;
    logic [3:0] rd_y = 4'd0;
    logic       rd_celula;
    logic [3:0] qtd_j0;
    logic [3:0] qtd_j1;

    validador_pecas #(
        .N_LADO (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valida     (valida),
        .tipo       (tipo),
        .jogador    (jogador),
        .X1         (X1),
        .Y1         (Y1),
        .direcao    (direcao),
        .orientacao (orientacao),
        .conflito   (conflito),
        .pronto     (pronto),
        .ocupado    (ocupado),
        .rd_jogador (rd_jogador),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_celula  (rd_celula),
        .qtd_j0     (qtd_j0),
        .qtd_j1     (qtd_j1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int conf;
        int ciclo;
    } esperado_t;

    esperado_t fila[$];
    int        vectors = 0;
    int        miscompares = 0;
    bit        modelo [2][N][N];
    int        qtd_modelo [2];

    task automatic checkOutput(input string nome, input int atual, input int requerido);
        vectors++;
        if (atual != requerido) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nome, atual, requerido);
        end
    endtask

    task automatic limpaModelo();
        for (int j = 0; j < 2; j++) begin
            qtd_modelo[j] = 0;
            for (int y = 0; y < N; y++) begin
                for (int x = 0; x < N; x++) begin
                    modelo[j][y][x] = 1'b0;
                end
            end
        end
        fila.delete();
    endtask

    // Monitor: every pronto must match the oldest outstanding request.
    always @(negedge clk) begin
        esperado_t e;
        if (reset && pronto) begin
            if (fila.size() == 0) begin
                checkOutput("pronto_inesperado", 1, 0);
            end else begin
                e = fila.pop_front();
                checkOutput("conflito", int'(conflito), e.conf);
                checkOutput("ciclo_pronto", cyc, e.ciclo);
            end
        end
    end

    task automatic waitIdle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ocupado && n < 40);
        checkOutput("timeout_ocupado", int'(ocupado), 0);
        checkOutput("pronto_pendente", fila.size(), 0);
    endtask

    // acao: 0 plain request, 1 extra valida pulse during the write phase,
    // 2 reset pulse during the write phase.
    task automatic applyStimulus(input int t, input int j, input int x, input int y,
                                 input int d, input int o, input int acao);
        int        len;
        int        lat;
        int        d0;
        int        conf;
        int        px[$];
        int        py[$];
        esperado_t e;

        @(negedge clk);
        valida     = 1'b1;
        tipo       = t[2:0];
        jogador    = j[0];
        X1         = x[3:0];
        Y1         = y[3:0];
        direcao    = d[0];
        orientacao = o[2:0];
        d0         = cyc;

        conf = 0;
        if (t > 4) begin
            conf = 1;
            lat  = 1;
        end else begin
            len = t + 1;
            lat = len + 1;
            for (int c = 0; c < len; c++) begin
                int along;
                int across;
                int cx;
                int cy;
                along  = c;
                across = 0;
                if (t == 2 && c == 1) across = o[0] ? -1 : 1;
                cx = d[0] ? x + across : x + along;
                cy = d[0] ? y + along : y + across;
                if (cx < 0 || cx >= N || cy < 0 || cy >= N) begin
                    conf = 1;
                end else begin
                    if (modelo[j][cy][cx]) conf = 1;
                    px.push_back(cx);
                    py.push_back(cy);
                end
            end
            if (conf == 0) begin
                foreach (px[i]) modelo[j][py[i]][px[i]] = 1'b1;
                if (qtd_modelo[j] < 15) qtd_modelo[j]++;
            end
        end
        e.conf  = conf;
        e.ciclo = d0 + lat;
        fila.push_back(e);

        @(negedge clk);
        valida     = 1'b0;
        tipo       = 3'($urandom);
        jogador    = 1'($urandom);
        X1         = 4'($urandom);
        Y1         = 4'($urandom);
        direcao    = 1'($urandom);
        orientacao = 3'($urandom);

        if (acao != 0) begin
            while (cyc < d0 + lat + 2) @(negedge clk);
            if (acao == 1) begin
                valida = 1'b1;
                @(negedge clk);
                valida = 1'b0;
            end else begin
                reset = 1'b0;
                @(negedge clk);
                checkOutput("ocupado_apos_reset", int'(ocupado), 0);
                checkOutput("qtd_j0_apos_reset", int'(qtd_j0), 0);
                checkOutput("qtd_j1_apos_reset", int'(qtd_j1), 0);
                checkOutput("conflito_apos_reset", int'(conflito), 0);
                reset = 1'b1;
                limpaModelo();
            end
        end
        waitIdle();
    endtask

    task automatic checkBoard();
        for (int j = 0; j < 2; j++) begin
            for (int y = 0; y < N; y++) begin
                for (int x = 0; x <= N; x++) begin
                    int req;
                    @(negedge clk);
                    rd_jogador = j[0];
                    rd_x       = x[3:0];
                    rd_y       = y[3:0];
                    req        = (x < N) ? int'(modelo[j][y][x]) : 0;
                    @(negedge clk);
                    checkOutput($sformatf("rd_celula j%0d (%0d,%0d)", j, x, y), int'(rd_celula), req);
                end
            end
        end
        checkOutput("qtd_j0", int'(qtd_j0), qtd_modelo[0]);
        checkOutput("qtd_j1", int'(qtd_j1), qtd_modelo[1]);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_ocupado", int'(ocupado), 0);
        checkOutput("reset_pronto", int'(pronto), 0);
        checkOutput("reset_conflito", int'(conflito), 0);
        checkOutput("reset_qtd_j0", int'(qtd_j0), 0);
        checkOutput("reset_qtd_j1", int'(qtd_j1), 0);
        reset = 1'b1;
        limpaModelo();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        limpaModelo();

        // Reset with valida already high; release must not start a check.
        valida = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ocupado", int'(ocupado), 0);
        checkOutput("reset_pronto", int'(pronto), 0);
        checkOutput("reset_conflito", int'(conflito), 0);
        checkOutput("reset_rd_celula", int'(rd_celula), 0);
        checkOutput("reset_qtd_j0", int'(qtd_j0), 0);
        checkOutput("reset_qtd_j1", int'(qtd_j1), 0);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checkOutput("ocupado_valida_alto_no_reset", int'(ocupado), 0);
        end
        valida = 1'b0;
        @(negedge clk);

        // Directed placements.
        applyStimulus(4, 0, 0, 0, 0, 0, 0);
        checkOutput("req035_conflito", int'(conflito), 0);
        checkOutput("req035_qtd_j0", int'(qtd_j0), 1);
        applyStimulus(1, 0, 3, 0, 1, 0, 0);
        checkOutput("req036_conflito", int'(conflito), 1);
        applyStimulus(3, 1, 7, 2, 0, 0, 0);
        checkOutput("req037_conflito", int'(conflito), 1);
        applyStimulus(2, 1, 0, 0, 0, 1, 0);
        checkOutput("req038a_conflito", int'(conflito), 1);
        applyStimulus(2, 1, 0, 0, 0, 0, 0);
        checkOutput("req038b_conflito", int'(conflito), 0);
        checkBoard();

        applyStimulus(6, 0, 5, 5, 0, 0, 0);
        checkOutput("tipo_invalido_conflito", int'(conflito), 1);
        applyStimulus(4, 1, 0, 9, 0, 0, 1);
        checkBoard();

        applyStimulus(3, 0, 0, 5, 0, 0, 2);
        checkBoard();

        // Piece counter saturation.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(0, 0, i % N, 4 + i / N, 0, 0, 0);
        end
        checkOutput("qtd_j0_saturada", int'(qtd_j0), 15);

        // Randomized rounds.
        for (int rodada = 0; rodada < 2; rodada++) begin
            doReset();
            for (int n = 0; n < 40; n++) begin
                int r;
                int t;
                r = int'($urandom_range(0, 11));
                t = (r > 7) ? r - 8 : r;
                applyStimulus(t, int'($urandom_range(0, 1)), int'($urandom_range(0, 11)),
                              int'($urandom_range(0, 11)), int'($urandom_range(0, 1)),
                              int'($urandom_range(0, 7)), 0);
            end
            checkBoard();
        end

        checkOutput("fila_vazia_final", fila.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
